// File: rtl/mem_wb_stage.sv
// Memory-stage controller and M->W pipeline register.
// Issues one load/store at a time over a req/ack handshake, stalls the
// upstream pipeline while the access is outstanding, aborts on timeout
// (sticky bus_err) and registers the retiring instruction into W.
module mem_wb_stage #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ValidM,
    input  logic             RegWriteM,
    input  logic [1:0]       ResultSrcM,
    input  logic             MemWriteM,
    input  logic [WIDTH-1:0] ALUResultM,
    input  logic [WIDTH-1:0] WriteDataM,
    input  logic [4:0]       RdM,
    input  logic [WIDTH-1:0] PCPlus4M,
    output logic             StallM,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ack,
    output logic             ValidW,
    output logic             RegWriteW,
    output logic [1:0]       ResultSrcW,
    output logic [WIDTH-1:0] ALUResultW,
    output logic [WIDTH-1:0] ReadDataW,
    output logic [WIDTH-1:0] PCPlus4W,
    output logic [4:0]       RdW,
    output logic [WIDTH-1:0] ResultW,
    output logic             bus_err
);

    typedef enum logic [0:0] {IDLE, ACCESS} state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;

    // Copy of the instruction whose access is outstanding
    logic               lat_we;
    logic [WIDTH-1:0]   lat_addr;
    logic [WIDTH-1:0]   lat_wdata;
    logic [4:0]         lat_rd;
    logic               lat_regwrite;
    logic [1:0]         lat_resultsrc;
    logic [WIDTH-1:0]   lat_pcplus4;

    logic               memop;
    logic               latch_en;
    logic               retire;
    logic               load_retire;
    logic               abort;
    logic               ret_regwrite;
    logic [1:0]         ret_resultsrc;
    logic [WIDTH-1:0]   ret_alu;
    logic [WIDTH-1:0]   ret_pcplus4;
    logic [4:0]         ret_rd;
    logic               timed_out;

    assign memop     = ValidM & (MemWriteM | (ResultSrcM == 2'b01));
    assign timed_out = (cnt_reg == CNT_W'(TIMEOUT));

    // Next-state, handshake outputs and retire selection
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        mem_req       = 1'b0;
        mem_we        = MemWriteM;
        mem_addr      = ALUResultM;
        mem_wdata     = WriteDataM;
        StallM        = 1'b0;
        latch_en      = 1'b0;
        retire        = 1'b0;
        load_retire   = 1'b0;
        abort         = 1'b0;
        ret_regwrite  = RegWriteM;
        ret_resultsrc = ResultSrcM;
        ret_alu       = ALUResultM;
        ret_pcplus4   = PCPlus4M;
        ret_rd        = RdM;
        case (state_reg)
            IDLE: begin
                mem_req = memop;
                if (memop && !mem_ack) begin
                    StallM     = 1'b1;
                    latch_en   = 1'b1;
                    state_next = ACCESS;
                    cnt_next   = CNT_W'(1);
                end else begin
                    retire      = ValidM;
                    load_retire = memop & ~MemWriteM;
                end
            end
            ACCESS: begin
                mem_req       = 1'b1;
                mem_we        = lat_we;
                mem_addr      = lat_addr;
                mem_wdata     = lat_wdata;
                ret_regwrite  = lat_regwrite;
                ret_resultsrc = lat_resultsrc;
                ret_alu       = lat_addr;
                ret_pcplus4   = lat_pcplus4;
                ret_rd        = lat_rd;
                // Ack takes priority over a coincident timeout
                if (mem_ack) begin
                    retire      = 1'b1;
                    load_retire = ~lat_we;
                    state_next  = IDLE;
                end else if (timed_out) begin
                    abort      = 1'b1;
                    state_next = IDLE;
                end else begin
                    StallM   = 1'b1;
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
        // Reset must silence the bus and release the pipeline immediately
        if (!rst_n) begin
            mem_req = 1'b0;
            StallM  = 1'b0;
        end
    end

    // FSM state, wait counter and sticky error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            bus_err   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (abort) bus_err <= 1'b1;
        end
    end

    // Capture the instruction when its access cannot complete immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_we        <= 1'b0;
            lat_addr      <= '0;
            lat_wdata     <= '0;
            lat_rd        <= '0;
            lat_regwrite  <= 1'b0;
            lat_resultsrc <= '0;
            lat_pcplus4   <= '0;
        end else if (latch_en) begin
            lat_we        <= MemWriteM;
            lat_addr      <= ALUResultM;
            lat_wdata     <= WriteDataM;
            lat_rd        <= RdM;
            lat_regwrite  <= RegWriteM;
            lat_resultsrc <= ResultSrcM;
            lat_pcplus4   <= PCPlus4M;
        end
    end

    // W-stage register: valid/write-enable every edge, payload only on retire
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ValidW     <= 1'b0;
            RegWriteW  <= 1'b0;
            ResultSrcW <= '0;
            ALUResultW <= '0;
            ReadDataW  <= '0;
            PCPlus4W   <= '0;
            RdW        <= '0;
        end else begin
            ValidW    <= retire;
            RegWriteW <= retire & ret_regwrite & (ret_rd != 5'd0);
            if (retire) begin
                ResultSrcW <= ret_resultsrc;
                ALUResultW <= ret_alu;
                PCPlus4W   <= ret_pcplus4;
                RdW        <= ret_rd;
            end
            if (load_retire) ReadDataW <= mem_rdata;
        end
    end

    // Writeback result select (11 aliases the ALU path)
    always_comb begin
        case (ResultSrcW)
            2'b01:   ResultW = ReadDataW;
            2'b10:   ResultW = PCPlus4W;
            default: ResultW = ALUResultW;
        endcase
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory-stage controller plus Memory→Writeback pipeline register; it consumes the Execute→Memory register outputs.
- Issues load/store transactions to a variable-latency data memory over a req/ack handshake.
- Stalls the upstream pipeline while an access is outstanding.
- Registers the completed instruction into the W stage and produces the selected writeback result.

Parameters:
- WIDTH, 32, datapath/address width.
- TIMEOUT, 16, max cycles waiting for mem_ack before abort (≥1).
- CNT_W, 5, width of the wait counter (must hold TIMEOUT).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ValidM  in  1  M-stage holds a real instruction.
- RegWriteM  in  1  instruction writes the register file.
- ResultSrcM  in  2  result select: 00 ALU, 01 memory read, 10 PC+4, 11 ALU.
- MemWriteM  in  1  store.
- ALUResultM  in  WIDTH  effective address or ALU result.
- WriteDataM  in  WIDTH  store data.
- RdM  in  5  destination register.
- PCPlus4M  in  WIDTH  return address.
- StallM  out  1  hold the E/M register and everything upstream.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write.
- mem_addr  out  WIDTH  byte address.
- mem_wdata  out  WIDTH  write data.
- mem_rdata  in  WIDTH  read data, valid with mem_ack.
- mem_ack  in  1  transaction complete.
- ValidW, RegWriteW  out  1  W-stage instruction valid / register-file write enable.
- ResultSrcW  out  2  registered select.
- ALUResultW, ReadDataW, PCPlus4W  out  WIDTH  registered operands.
- RdW  out  5  registered destination.
- ResultW  out  WIDTH  combinational mux of the W registers per ResultSrcW (11 → ALU).
- bus_err  out  1  sticky timeout flag.

Behaviour:
- Memory op (memop) = ValidM & (MemWriteM | ResultSrcM==01).
- Reset (async, rst_n=0):
  - FSM to IDLE, counter cleared.
  - All W registers 0, bus_err 0, mem_req 0, StallM 0.
  - Reset mid-access abandons the transaction with no retry.
- FSM states: IDLE, ACCESS.
- IDLE:
  - mem_req = memop; mem_we/mem_addr/mem_wdata driven directly from MemWriteM/ALUResultM/WriteDataM.
  - memop & mem_ack (zero-wait): instruction retires into W at this edge; StallM=0.
  - memop & !mem_ack: latch we/addr/wdata/RdM/RegWriteM/ResultSrcM/PCPlus4M/ALUResultM internally; go to ACCESS; counter←1; StallM=1.
  - Non-memop: retires into W next edge; StallM=0; mem_req=0.
- ACCESS:
  - mem_req=1; address/data/we come from the latched copy and are stable until ack.
  - StallM=1 except on the completing or aborting cycle.
  - mem_ack: retire the latched instruction into W with ReadDataW←mem_rdata; go to IDLE; StallM=0 this cycle.
  - !mem_ack & counter==TIMEOUT: abort; bus_err←1 (sticky until reset); W gets a bubble; go to IDLE; StallM=0.
  - mem_ack and timeout in the same cycle: ack wins, normal retire.
  - Otherwise counter increments.
- W register update every edge:
  - Retiring instruction: ValidW=1; RegWriteW = RegWrite & (Rd≠0); other fields copied.
  - Non-retiring cycle (stall, bubble, ValidM=0, abort): ValidW=0, RegWriteW=0, other fields don't-care but hold.
- ReadDataW updates only on a load retire.
- Stores retire with RegWriteW as supplied; normally 0.
- Latency:
  - Non-memory instruction: 1 cycle M→W.
  - Memory instruction: 1 + wait cycles.
  - One transaction outstanding max.

Test Plan:
- ALU op: ValidM=1, RegWriteM=1, ResultSrcM=00, ALUResultM=0x1234, RdM=5 → next cycle ValidW=1, RegWriteW=1, RdW=5, ResultW=0x1234; mem_req never asserted.
- Zero-wait load: addr 0x40, mem_ack same cycle, mem_rdata=0xDEADBEEF → StallM stays 0; next cycle ResultW=0xDEADBEEF.
- 3-wait store: addr 0x80, wdata 0xA5A5A5A5, ack on 4th req cycle → mem_req high 4 cycles with constant addr/wdata/we=1; StallM high 3 cycles; ValidW=0 during the wait; RegWriteW=0.
- Timeout: load, no ack, TIMEOUT=16 → StallM released after 16 ACCESS cycles; bus_err=1 and stays 1; W bubble (RegWriteW=0). Repeat with ack exactly at counter==16 → normal retire, bus_err unchanged.
- Rd=x0 with RegWriteM=1 → RegWriteW=0.
- JAL-style ResultSrcM=10, PCPlus4M=0x104 → ResultW=0x104.
- Assert rst_n=0 during ACCESS mid-wait → mem_req, StallM, ValidW, bus_err immediately 0 (async); after release, a following ALU op retires normally.
